// File: rtl/sgmii_pcs_pkg.sv
// Shared constants and types for the SGMII PCS transmit path with rate adaptation.
package sgmii_pcs_pkg;

  // Code-group values ahead of the 8b/10b encoder
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;

  // XMIT modes from autonegotiation
  localparam logic [2:0] XMIT_IDLE   = 3'b001;
  localparam logic [2:0] XMIT_CONFIG = 3'b010;
  localparam logic [2:0] XMIT_DATA   = 3'b100;

  // Speed select
  localparam logic [1:0] SPD_1000 = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_10   = 2'b10;

  // Ordered-set FSM states, one-hot
  localparam logic [7:0] ST_TEST = 8'b0000_0001;
  localparam logic [7:0] ST_CFG  = 8'b0000_0010;
  localparam logic [7:0] ST_IDLE = 8'b0000_0100;
  localparam logic [7:0] ST_SERR = 8'b0000_1000;
  localparam logic [7:0] ST_DATA = 8'b0001_0000;
  localparam logic [7:0] ST_EOP1 = 8'b0010_0000;
  localparam logic [7:0] ST_EOP2 = 8'b0100_0000;
  localparam logic [7:0] ST_EXT  = 8'b1000_0000;

  // One GMII transfer as stored in the input FIFO
  typedef struct packed {
    logic       en;
    logic       er;
    logic [7:0] d;
  } gmii_word_t;

  // Number of code-group cycles each GMII byte occupies at a given speed
  function automatic int unsigned rep_count(input logic [1:0] spd,
                                            input int unsigned r100,
                                            input int unsigned r10);
    case (spd)
      SPD_100: return r100;
      SPD_10:  return r10;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/sgmii_tx_rate_replicator.sv
// Input FIFO plus byte replicator: turns sparse GMII writes into one virtual
// GMII word per code-group cycle, repeating each byte per the selected speed.
module sgmii_tx_rate_replicator
  import sgmii_pcs_pkg::*;
#(
  parameter int pFifoPtrWidth = 3,
  parameter int pRep100       = 10,
  parameter int pRep10        = 100
) (
  input  logic       i_Clk,
  input  logic       i_ARst_L,
  input  logic       i_Enable,
  input  logic [1:0] i2_Speed,
  input  logic       i_Wr,
  input  gmii_word_t i_WrWord,
  output gmii_word_t o_Word,
  output logic       o_FifoOverflow,
  output logic       o_Underrun
);
  localparam int DEPTH = 2 ** pFifoPtrWidth;
  localparam int CW    = $clog2(pRep10 + 1);

  gmii_word_t               r_mem [DEPTH];
  logic [pFifoPtrWidth:0]   r_wp, r_rp;
  logic [CW-1:0]            r_cnt, r_rep;
  logic                     r_held;
  gmii_word_t               r_word;
  logic                     r_ovf, r_und;

  logic          w_empty, w_full, w_bound;
  logic [CW-1:0] w_rep;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[pFifoPtrWidth] != r_rp[pFifoPtrWidth]) &&
                   (r_wp[pFifoPtrWidth-1:0] == r_rp[pFifoPtrWidth-1:0]);
  assign w_bound = (r_cnt == '0);
  // Speed is only re-read when no entry was being replicated
  assign w_rep   = r_held ? r_rep : CW'(rep_count(i2_Speed, pRep100, pRep10) - 1);

  // FIFO storage, no reset needed
  always_ff @(posedge i_Clk) begin
    if (i_Wr && !w_full) r_mem[r_wp[pFifoPtrWidth-1:0]] <= i_WrWord;
  end

  // Pointers, repeat counter and the current virtual word
  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_rep  <= '0;
      r_held <= 1'b0;
      r_word <= '0;
      r_ovf  <= 1'b0;
      r_und  <= 1'b0;
    end else begin
      r_ovf <= i_Wr && w_full;
      r_und <= 1'b0;
      if (i_Wr && !w_full) r_wp <= r_wp + 1'b1;
      if (i_Enable) begin
        if (w_bound) begin
          if (!w_empty) begin
            r_word <= r_mem[r_rp[pFifoPtrWidth-1:0]];
            r_rp   <= r_rp + 1'b1;
            r_cnt  <= w_rep;
            r_rep  <= w_rep;
            r_held <= 1'b1;
          end else begin
            r_word <= '0;
            r_held <= 1'b0;
            r_und  <= r_word.en;
          end
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign o_Word         = r_word;
  assign o_FifoOverflow = r_ovf;
  assign o_Underrun     = r_und;

endmodule

// File: rtl/sgmii_pcs_tx_ra.sv
// SGMII/1000BASE-X PCS transmit ordered-set generator with rate adaptation.
module sgmii_pcs_tx_ra
  import sgmii_pcs_pkg::*;
#(
  parameter int pFifoPtrWidth = 3,
  parameter int pRep100       = 10,
  parameter int pRep10        = 100
) (
  input  logic        i_Clk,
  input  logic        i_ARst_L,
  input  logic [2:0]  i3_Xmit,
  input  logic [15:0] i16_ConfigReg,
  input  logic [1:0]  i2_Speed,
  input  logic        i_TxValid,
  input  logic        i_TxEN,
  input  logic        i_TxER,
  input  logic [7:0]  i8_TxD,
  input  logic        i_CurrentParity,
  output logic [7:0]  o8_TxCodeGroupOut,
  output logic        o_TxCodeCtrl,
  output logic        o_TxEven,
  output logic        o_Xmitting,
  output logic        o_FifoOverflow,
  output logic        o_Underrun
);
  gmii_word_t  w_vw;
  logic        w_wr, w_slotEven, w_chg;
  logic [7:0]  w_idleD;

  logic [7:0]  r_state, n_state;
  logic [2:0]  r_xmit, n_xmit;
  logic [2:0]  r_cpos, n_cpos;
  logic [15:0] r_cfg, n_cfg;
  logic        r_even;
  logic [7:0]  r_cg, n_cg;
  logic        r_k, n_k, r_xm, n_xm;

  assign w_wr = i_TxValid && (i_TxEN || i_TxER);

  sgmii_tx_rate_replicator #(
    .pFifoPtrWidth (pFifoPtrWidth),
    .pRep100       (pRep100),
    .pRep10        (pRep10)
  ) u_rep (
    .i_Clk          (i_Clk),
    .i_ARst_L       (i_ARst_L),
    .i_Enable       (r_xmit == XMIT_DATA),
    .i2_Speed       (i2_Speed),
    .i_Wr           (w_wr),
    .i_WrWord       ({i_TxEN, i_TxER, i8_TxD}),
    .o_Word         (w_vw),
    .o_FifoOverflow (o_FifoOverflow),
    .o_Underrun     (o_Underrun)
  );

  // The slot produced at the coming edge is even when the current one is odd
  assign w_slotEven = ~r_even;
  assign w_idleD    = i_CurrentParity ? D16_2 : D5_6;
  assign w_chg      = w_slotEven && (r_state != ST_TEST) && (i3_Xmit != r_xmit);

  // Next code group and state; an XMIT change preempts everything at an even slot
  always_comb begin
    n_state = r_state;
    n_xmit  = r_xmit;
    n_cpos  = r_cpos;
    n_cfg   = r_cfg;
    n_cg    = K28_5;
    n_k     = 1'b1;
    n_xm    = 1'b0;
    if (w_chg) begin
      n_state = ST_TEST;
    end else begin
      case (r_state)
        ST_TEST: begin
          if (w_slotEven) begin
            n_xmit = i3_Xmit;
            if (i3_Xmit == XMIT_CONFIG) begin
              n_state = ST_CFG;
              n_cpos  = 3'd1;
              n_cfg   = i16_ConfigReg;
            end else begin
              n_state = ST_IDLE;
            end
          end else begin
            n_cg = w_idleD;
            n_k  = 1'b0;
          end
        end
        ST_CFG: begin
          n_cpos = r_cpos + 3'd1;
          n_k    = 1'b0;
          case (r_cpos)
            3'd0, 3'd4: begin n_cg = K28_5; n_k = 1'b1; n_cfg = i16_ConfigReg; end
            3'd1:       n_cg = D21_5;
            3'd5:       n_cg = D2_2;
            3'd2, 3'd6: n_cg = r_cfg[7:0];
            default:    n_cg = r_cfg[15:8];
          endcase
        end
        ST_IDLE: begin
          if (w_slotEven) begin
            if (r_xmit == XMIT_DATA && w_vw.en) begin
              n_cg    = K27_7;
              n_xm    = 1'b1;
              n_state = w_vw.er ? ST_SERR : ST_DATA;
            end
          end else begin
            n_cg = w_idleD;
            n_k  = 1'b0;
          end
        end
        ST_SERR: begin
          n_cg    = K30_7;
          n_xm    = 1'b1;
          n_state = ST_DATA;
        end
        ST_DATA: begin
          if (w_vw.en) begin
            n_xm = 1'b1;
            if (w_vw.er) n_cg = K30_7;
            else begin n_cg = w_vw.d; n_k = 1'b0; end
          end else if (w_vw.er) begin
            n_cg    = (w_vw.d == 8'h0F) ? K23_7 : K30_7;
            n_state = ST_EXT;
          end else begin
            n_cg    = K29_7;
            n_xm    = 1'b1;
            n_state = ST_EOP1;
          end
        end
        ST_EOP1: begin
          n_cg    = K23_7;
          n_state = w_slotEven ? ST_EOP2 : ST_IDLE;
        end
        ST_EOP2: begin
          n_cg    = K23_7;
          n_state = ST_IDLE;
        end
        ST_EXT: begin
          if (w_vw.en && !w_vw.er && w_slotEven) begin
            n_cg    = K27_7;
            n_xm    = 1'b1;
            n_state = ST_DATA;
          end else if (w_vw.er) begin
            n_cg = (w_vw.d == 8'h0F) ? K23_7 : K30_7;
          end else if (w_vw.en) begin
            n_cg = K23_7;
          end else begin
            n_cg    = K23_7;
            n_state = w_slotEven ? ST_EOP2 : ST_IDLE;
          end
        end
        default: n_state = ST_TEST;
      endcase
    end
  end

  // Registered outputs, FSM state and slot parity
  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) begin
      r_state <= ST_TEST;
      r_xmit  <= 3'b000;
      r_cpos  <= 3'd0;
      r_cfg   <= 16'h0000;
      r_even  <= 1'b0;
      r_cg    <= 8'h00;
      r_k     <= 1'b0;
      r_xm    <= 1'b0;
    end else begin
      r_state <= n_state;
      r_xmit  <= n_xmit;
      r_cpos  <= n_cpos;
      r_cfg   <= n_cfg;
      r_even  <= ~r_even;
      r_cg    <= n_cg;
      r_k     <= n_k;
      r_xm    <= n_xm;
    end
  end

  assign o8_TxCodeGroupOut = r_cg;
  assign o_TxCodeCtrl      = r_k;
  assign o_TxEven          = r_even;
  assign o_Xmitting        = r_xm;

endmodule
